// File: rtl/rf_window_seq_if.sv
// Sequencer bundle: start/busy/done control, pixel stream, register-file pins
// and the window handoff to the MAC.
interface rf_window_seq_if #(
  parameter int M = 4,
  parameter int W = 8
);
  logic         start;
  logic         busy;
  logic         done;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         rf_we;
  logic [M-1:0] rf_waddr;
  logic [W-1:0] rf_wdata;
  logic         rf_re;
  logic [M-1:0] rf_raddr1;
  logic [M-1:0] rf_raddr2;
  logic [M-1:0] rf_raddr3;
  logic         win_valid;
  logic [M-1:0] win_idx;
  logic         win_ready;

  modport master (
    input  start, in_valid, in_data, win_ready,
    output busy, done, in_ready, rf_we, rf_waddr, rf_wdata,
           rf_re, rf_raddr1, rf_raddr2, rf_raddr3, win_valid, win_idx
  );

  modport slave (
    output start, in_valid, in_data, win_ready,
    input  busy, done, in_ready, rf_we, rf_waddr, rf_wdata,
           rf_re, rf_raddr1, rf_raddr2, rf_raddr3, win_valid, win_idx
  );
endinterface

// File: rtl/rf_window_seq.sv
// Loads N pixels into the 3R/1W register file, then sweeps a 3-tap sliding
// window over them with a valid/ready handoff to the MAC.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | streaming pixels into the file, one write per accepted beat
// RUN   | issuing window reads; win_valid marks ReadData1..3 holding win_idx
// DONE  | sweep finished; done pulses on the second DONE cycle
module rf_window_seq #(
  parameter int M = 4,
  parameter int N = 15,
  parameter int W = 8
) (
  input logic clk,
  input logic rst,
  rf_window_seq_if.master bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [M-1:0] LastWr  = M'(N - 1);
  localparam logic [M-1:0] LastWin = M'(N - 3);

  state_t       state;
  logic [M-1:0] wrCnt;
  logic [M-1:0] rdCnt;
  logic [M-1:0] winIdx;
  logic         winValid;
  logic         doneReg;
  logic         wrBeat;
  logic         issue;
  logic         accept;

  assign wrBeat = (state == LOAD) && bus.in_valid;
  assign accept = winValid && bus.win_ready;
  // A stalled window blocks new reads so the file keeps ReadData stable.
  assign issue  = (state == RUN) && (rdCnt <= LastWin) && (!winValid || bus.win_ready);

  assign bus.busy      = (state != IDLE);
  assign bus.done      = doneReg;
  assign bus.in_ready  = (state == LOAD);
  assign bus.rf_we     = wrBeat;
  assign bus.rf_waddr  = wrBeat ? wrCnt : '0;
  assign bus.rf_wdata  = wrBeat ? bus.in_data : '0;
  assign bus.rf_re     = issue;
  assign bus.rf_raddr1 = issue ? rdCnt : '0;
  assign bus.rf_raddr2 = issue ? rdCnt + M'(1) : '0;
  assign bus.rf_raddr3 = issue ? rdCnt + M'(2) : '0;
  assign bus.win_valid = winValid;
  assign bus.win_idx   = winIdx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wrCnt    <= '0;
      rdCnt    <= '0;
      winValid <= 1'b0;
      winIdx   <= '0;
      doneReg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= LOAD;
            wrCnt <= '0;
            rdCnt <= '0;
          end
        end
        LOAD: begin
          if (wrBeat) begin
            if (wrCnt == LastWr) state <= RUN;
            else                 wrCnt <= wrCnt + M'(1);
          end
        end
        RUN: begin
          if (issue) begin
            rdCnt    <= rdCnt + M'(1);
            winValid <= 1'b1;
            winIdx   <= rdCnt;
          end else if (accept) begin
            winValid <= 1'b0;
            winIdx   <= '0;
          end
          if (accept && (winIdx == LastWin)) state <= DONE;
        end
        DONE: begin
          // done is registered here, so it lands one cycle after DONE entry
          if (doneReg) begin
            doneReg <= 1'b0;
            state   <= IDLE;
          end else begin
            doneReg <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_window_seq.sv
// Directed bench for rf_window_seq with a behavioural register file per instance
// and write/window scoreboards (N=15 and N=3 instances).
module tb_rf_window_seq;
  localparam int M  = 4;
  localparam int W  = 8;
  localparam int NA = 15;
  localparam int NB = 3;

  typedef struct packed {
    logic [M-1:0] addr;
    logic [W-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [M-1:0] idx;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [W-1:0] d3;
  } win_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_window_seq_if #(.M(M), .W(W)) ifA ();
  rf_window_seq_if #(.M(M), .W(W)) ifB ();

  rf_window_seq #(.M(M), .N(NA), .W(W)) dutA (.clk(clk), .rst(rst), .bus(ifA));
  rf_window_seq #(.M(M), .N(NB), .W(W)) dutB (.clk(clk), .rst(rst), .bus(ifB));

  // Behavioural 3R/1W files with registered read data.
  logic [W-1:0] memA [16];
  logic [W-1:0] memB [16];
  logic [W-1:0] rdA1, rdA2, rdA3, rdB1, rdB2, rdB3;

  always_ff @(posedge clk) begin
    if (ifA.rf_we) memA[ifA.rf_waddr] <= ifA.rf_wdata;
    if (ifA.rf_re) begin
      rdA1 <= memA[ifA.rf_raddr1];
      rdA2 <= memA[ifA.rf_raddr2];
      rdA3 <= memA[ifA.rf_raddr3];
    end
    if (ifB.rf_we) memB[ifB.rf_waddr] <= ifB.rf_wdata;
    if (ifB.rf_re) begin
      rdB1 <= memB[ifB.rf_raddr1];
      rdB2 <= memB[ifB.rf_raddr2];
      rdB3 <= memB[ifB.rf_raddr3];
    end
  end

  wr_t  wrQa[$], wrQb[$];
  win_t winQa[$], winQb[$];

  int nAssert = 0;
  int nFail   = 0;
  int cycNum  = 0;
  int doneCntA = 0, doneCycA = -1, winAccA = 0;
  int doneCntB = 0, doneCycB = -1, winAccB = 0;
  int tA, tB, doneBaseA, winBaseA, doneBaseB, winBaseB;
  logic [W-1:0] pix [NA];
  logic [W-1:0] pb [NB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor/scoreboard at negedge, then advance to just after posedge.
  task automatic cyc();
    wr_t  w;
    win_t x;
    @(negedge clk);
    if (ifA.rf_we) begin
      if (wrQa.size() == 0) chk("A_wr_extra_addr", 32'(ifA.rf_waddr), 32'hFFFF_FFFF);
      else begin
        w = wrQa.pop_front();
        chk("A_wr_addr", 32'(ifA.rf_waddr), 32'(w.addr));
        chk("A_wr_data", 32'(ifA.rf_wdata), 32'(w.data));
      end
    end
    if (ifA.win_valid && ifA.win_ready) begin
      winAccA++;
      if (winQa.size() == 0) chk("A_win_extra_idx", 32'(ifA.win_idx), 32'hFFFF_FFFF);
      else begin
        x = winQa.pop_front();
        chk("A_win_idx", 32'(ifA.win_idx), 32'(x.idx));
        chk("A_win_d1", 32'(rdA1), 32'(x.d1));
        chk("A_win_d2", 32'(rdA2), 32'(x.d2));
        chk("A_win_d3", 32'(rdA3), 32'(x.d3));
      end
    end
    if (ifA.done) begin
      doneCntA++;
      doneCycA = cycNum;
    end
    if (ifB.rf_we) begin
      if (wrQb.size() == 0) chk("B_wr_extra_addr", 32'(ifB.rf_waddr), 32'hFFFF_FFFF);
      else begin
        w = wrQb.pop_front();
        chk("B_wr_addr", 32'(ifB.rf_waddr), 32'(w.addr));
        chk("B_wr_data", 32'(ifB.rf_wdata), 32'(w.data));
      end
    end
    if (ifB.win_valid && ifB.win_ready) begin
      winAccB++;
      if (winQb.size() == 0) chk("B_win_extra_idx", 32'(ifB.win_idx), 32'hFFFF_FFFF);
      else begin
        x = winQb.pop_front();
        chk("B_win_idx", 32'(ifB.win_idx), 32'(x.idx));
        chk("B_win_d1", 32'(rdB1), 32'(x.d1));
        chk("B_win_d2", 32'(rdB2), 32'(x.d2));
        chk("B_win_d3", 32'(rdB3), 32'(x.d3));
      end
    end
    if (ifB.done) begin
      doneCntB++;
      doneCycB = cycNum;
    end
    @(posedge clk);
    #1;
    cycNum++;
  endtask

  task automatic chkIdleA(input string tag);
    chk({tag, "_busy"},      32'(ifA.busy),      32'd0);
    chk({tag, "_done"},      32'(ifA.done),      32'd0);
    chk({tag, "_in_ready"},  32'(ifA.in_ready),  32'd0);
    chk({tag, "_rf_we"},     32'(ifA.rf_we),     32'd0);
    chk({tag, "_rf_waddr"},  32'(ifA.rf_waddr),  32'd0);
    chk({tag, "_rf_wdata"},  32'(ifA.rf_wdata),  32'd0);
    chk({tag, "_rf_re"},     32'(ifA.rf_re),     32'd0);
    chk({tag, "_rf_raddr1"}, 32'(ifA.rf_raddr1), 32'd0);
    chk({tag, "_rf_raddr2"}, 32'(ifA.rf_raddr2), 32'd0);
    chk({tag, "_rf_raddr3"}, 32'(ifA.rf_raddr3), 32'd0);
    chk({tag, "_win_valid"}, 32'(ifA.win_valid), 32'd0);
    chk({tag, "_win_idx"},   32'(ifA.win_idx),   32'd0);
  endtask

  task automatic fillPix(input logic [W-1:0] base, input logic [W-1:0] step);
    for (int i = 0; i < NA; i++) pix[i] = base + step * W'(i);
  endtask

  task automatic startA();
    ifA.start = 1'b1;
    tA = cycNum;
    doneBaseA = doneCntA;
    winBaseA = winAccA;
    cyc();
    ifA.start = 1'b0;
    chk("A_load_in_ready", 32'(ifA.in_ready), 32'd1);
    chk("A_load_busy", 32'(ifA.busy), 32'd1);
  endtask

  task automatic loadA(input int gap, input int startAt);
    for (int i = 0; i < NA; i++) begin
      ifA.in_valid = 1'b1;
      ifA.in_data  = pix[i];
      ifA.start    = (i == startAt);
      wrQa.push_back({M'(i), pix[i]});
      cyc();
      ifA.start = 1'b0;
      if (i < NA - 1) begin
        for (int g = 0; g < gap; g++) begin
          ifA.in_valid = 1'b0;
          ifA.in_data  = 8'hEE;
          #1;
          chk("A_gap_we", 32'(ifA.rf_we), 32'd0);
          chk("A_gap_in_ready", 32'(ifA.in_ready), 32'd1);
          chk("A_gap_re", 32'(ifA.rf_re), 32'd0);
          cyc();
        end
      end
    end
    ifA.in_valid = 1'b0;
    ifA.in_data  = '0;
    for (int i = 0; i <= NA - 3; i++) winQa.push_back({M'(i), pix[i], pix[i+1], pix[i+2]});
    #1;
    chk("A_run_in_ready", 32'(ifA.in_ready), 32'd0);
    chk("A_run_first_re", 32'(ifA.rf_re), 32'd1);
    chk("A_run_raddr1", 32'(ifA.rf_raddr1), 32'd0);
    chk("A_run_raddr3", 32'(ifA.rf_raddr3), 32'd2);
    chk("A_run_busy", 32'(ifA.busy), 32'd1);
  endtask

  task automatic waitIdxA(input int k);
    int found = 0;
    for (int j = 0; j < 60; j++) begin
      if (ifA.win_valid && (ifA.win_idx == M'(k))) begin
        found = 1;
        break;
      end
      cyc();
    end
    chk("A_reach_idx", 32'(found), 32'd1);
  endtask

  task automatic waitDoneA(input int expCyc, input int expWin);
    for (int k = 0; k < 100 && doneCntA == doneBaseA; k++) cyc();
    chk("A_done_count", 32'(doneCntA - doneBaseA), 32'd1);
    chk("A_done_cycle", 32'(doneCycA), 32'(expCyc));
    chk("A_busy_after_done", 32'(ifA.busy), 32'd0);
    chk("A_done_low_after", 32'(ifA.done), 32'd0);
    chk("A_windows", 32'(winAccA - winBaseA), 32'(expWin));
    chk("A_winq_empty", 32'(winQa.size()), 32'd0);
    cyc();
    cyc();
    chk("A_done_single", 32'(doneCntA - doneBaseA), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    ifA.start = 1'b0; ifA.in_valid = 1'b1; ifA.in_data = 8'h5A; ifA.win_ready = 1'b0;
    ifB.start = 1'b0; ifB.in_valid = 1'b0; ifB.in_data = '0;    ifB.win_ready = 1'b0;

    // Reset values, with in_valid high to show writes are gated outside LOAD.
    repeat (3) cyc();
    chkIdleA("rst");
    chk("rstB_busy", 32'(ifB.busy), 32'd0);
    chk("rstB_win_valid", 32'(ifB.win_valid), 32'd0);
    rst = 1'b0;
    ifA.in_valid = 1'b0;
    ifA.in_data = '0;
    cyc();
    chkIdleA("idle");

    // Back-to-back load of 1..15, win_ready held high.
    ifA.win_ready = 1'b1;
    fillPix(8'd1, 8'd1);
    startA();
    loadA(0, -1);
    waitDoneA(tA + 2*NA + 1, NA - 2);

    // in_valid toggling 1,0,1,0 during LOAD.
    fillPix(8'h40, 8'd3);
    startA();
    loadA(1, -1);
    waitDoneA(tA + 2*NA + 1 + (NA - 1), NA - 2);

    // Downstream stall for 3 cycles on window 5.
    fillPix(8'hA0, 8'hFF);
    startA();
    loadA(0, -1);
    waitIdxA(5);
    ifA.win_ready = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("stall_valid", 32'(ifA.win_valid), 32'd1);
      chk("stall_idx", 32'(ifA.win_idx), 32'd5);
      chk("stall_re", 32'(ifA.rf_re), 32'd0);
      chk("stall_raddr1", 32'(ifA.rf_raddr1), 32'd0);
      chk("stall_rd1", 32'(rdA1), 32'(pix[5]));
      chk("stall_rd2", 32'(rdA2), 32'(pix[6]));
      chk("stall_rd3", 32'(rdA3), 32'(pix[7]));
      cyc();
    end
    ifA.win_ready = 1'b1;
    #1;
    chk("release_idx", 32'(ifA.win_idx), 32'd5);
    chk("release_re", 32'(ifA.rf_re), 32'd1);
    chk("release_raddr1", 32'(ifA.rf_raddr1), 32'd6);
    cyc();
    chk("next_valid", 32'(ifA.win_valid), 32'd1);
    chk("next_idx", 32'(ifA.win_idx), 32'd6);
    waitDoneA(tA + 2*NA + 1 + 3, NA - 2);

    // start pulsed during LOAD, during RUN and in the done cycle.
    fillPix(8'd3, 8'd7);
    startA();
    loadA(0, 4);
    ifA.start = 1'b1;
    cyc();
    ifA.start = 1'b0;
    for (int k = 0; k < 100 && cycNum < tA + 2*NA + 1; k++) cyc();
    ifA.start = 1'b1;
    #1;
    chk("A_done_at_expected", 32'(ifA.done), 32'd1);
    cyc();
    ifA.start = 1'b0;
    chk("A_start_in_done_busy", 32'(ifA.busy), 32'd0);
    chk("A_start_in_done_ready", 32'(ifA.in_ready), 32'd0);
    cyc();
    chk("A_still_idle", 32'(ifA.busy), 32'd0);
    chk("A_dis_done_count", 32'(doneCntA - doneBaseA), 32'd1);
    chk("A_dis_done_cycle", 32'(doneCycA), 32'(tA + 2*NA + 1));
    chk("A_dis_windows", 32'(winAccA - winBaseA), 32'(NA - 2));
    chk("A_dis_winq_empty", 32'(winQa.size()), 32'd0);

    // Reset in the middle of RUN, then a clean restart.
    fillPix(8'h11, 8'h11);
    startA();
    loadA(0, -1);
    waitIdxA(7);
    rst = 1'b1;
    cyc();
    chkIdleA("midrun_rst");
    rst = 1'b0;
    winQa.delete();
    cyc();
    chk("A_post_rst_busy", 32'(ifA.busy), 32'd0);
    fillPix(8'hC0, 8'd1);
    startA();
    loadA(0, -1);
    waitDoneA(tA + 2*NA + 1, NA - 2);

    // N=3 instance: one window (9,8,7).
    pb = '{8'd9, 8'd8, 8'd7};
    ifB.win_ready = 1'b1;
    ifB.start = 1'b1;
    tB = cycNum;
    doneBaseB = doneCntB;
    winBaseB = winAccB;
    cyc();
    ifB.start = 1'b0;
    chk("B_load_in_ready", 32'(ifB.in_ready), 32'd1);
    for (int i = 0; i < NB; i++) begin
      ifB.in_valid = 1'b1;
      ifB.in_data  = pb[i];
      wrQb.push_back({M'(i), pb[i]});
      cyc();
    end
    ifB.in_valid = 1'b0;
    ifB.in_data  = '0;
    winQb.push_back({M'(0), pb[0], pb[1], pb[2]});
    for (int k = 0; k < 50 && doneCntB == doneBaseB; k++) cyc();
    chk("B_done_count", 32'(doneCntB - doneBaseB), 32'd1);
    chk("B_done_cycle", 32'(doneCycB), 32'(tB + 2*NB + 1));
    chk("B_windows", 32'(winAccB - winBaseB), 32'd1);
    chk("B_busy_after_done", 32'(ifB.busy), 32'd0);
    chk("B_winq_empty", 32'(winQb.size()), 32'd0);

    chk("A_wrq_empty", 32'(wrQa.size()), 32'd0);
    chk("B_wrq_empty", 32'(wrQb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule

// File: doc/rf_window_seq.md
# rf_window_seq

Sequencer for the 3-read/1-write register file in the single-layer CNN datapath. It loads N input pixels into the file through a valid/ready stream, then sweeps a 3-tap sliding window over them. For each window it issues read addresses i, i+1, i+2 and flags the cycle when the file's registered ReadData1..3 hold that window for the downstream MAC. The block owns the file's WriteEn/WriteReg/WriteData/ReadEn/ReadReg1..3 pins and contains no data storage of its own.

## Interface
- M, 4, address width (must match the register file M)
- N, 15, number of words loaded and window span; N >= 3, N <= 2^M
- W, 8, data width
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- start  in  1  begin a load+sweep; sampled only in IDLE
- busy  out  1  high in LOAD, RUN, DONE
- done  out  1  one-cycle pulse after the last window is accepted
- in_valid  in  1  input pixel valid
- in_data  in  W  input pixel
- in_ready  out  1  high only in LOAD
- rf_we  out  1  to WriteEn
- rf_waddr  out  M  to WriteReg
- rf_wdata  out  W  to WriteData
- rf_re  out  1  to ReadEn
- rf_raddr1, rf_raddr2, rf_raddr3  out  M each  to ReadReg1..3
- win_valid  out  1  ReadData1..3 currently hold window win_idx
- win_idx  out  M  index of the window on ReadData (first address)
- win_ready  in  1  downstream accepts the window

## Operation
- States are IDLE, LOAD, RUN and DONE.
- IDLE -> LOAD on start. start is ignored in every other state.
- LOAD behaviour:
  - in_ready = 1.
  - rf_we = in_valid, rf_waddr = wr_cnt, rf_wdata = in_data (combinational pass-through).
  - wr_cnt increments on each in_valid && in_ready and never wraps.
  - LOAD -> RUN on the beat where wr_cnt == N-1.
- RUN issue rule:
  - rf_re = 1 when rd_cnt <= N-3 and (!win_valid || win_ready).
  - Addresses are rf_raddr1 = rd_cnt, rf_raddr2 = rd_cnt+1, rf_raddr3 = rd_cnt+2.
  - rd_cnt increments on each issue.
- RUN valid rule:
  - win_valid is set the cycle after an issue, with win_idx = the issued rd_cnt.
  - win_valid stays high until win_valid && win_ready.
  - Accept and a new issue in the same cycle keeps win_valid high with the new win_idx. Throughput is 1 window/cycle.
  - While win_valid && !win_ready, rf_re = 0. The file then holds ReadData, so the window stays stable.
- RUN -> DONE when the window with win_idx == N-3 is accepted.
- DONE holds done = 1 for one cycle, then returns to IDLE.
- Outputs that are not driven are 0, including rf_we outside LOAD and rf_re outside RUN. Addresses are 0 when their enable is low.
- Exactly N writes and N-2 windows occur per start.
- Reset behaviour:
  - rst at any time, including mid-LOAD or mid-RUN, returns to IDLE and clears wr_cnt, rd_cnt, win_valid, win_idx and done. The partial sweep is abandoned.
  - Register-file contents are not cleared.
  - The top level drives the file's rst_n from ~rst.

## Timing
- Reset values are busy 0, done 0, in_ready 0, rf_we 0, rf_waddr 0, rf_wdata 0, rf_re 0, rf_raddr1..3 0, win_valid 0, win_idx 0.
- start at cycle t gives LOAD (in_ready = 1) at t+1.
- Last write at edge t. RUN begins at t+1, and the first rf_re is asserted in cycle t+1. There is no read-after-write hazard because the write has already landed.
- Read latency is 1: rf_re in cycle c gives win_valid in c+1, aligned with the file's ReadData.
- Minimum cycles from start to done, with in_valid and win_ready held high:
  - 1 to enter LOAD
  - N for the loads
  - N-2 for the issues
  - 1 for the last valid
  - done in the following cycle, so done is at t + 2N + 1 for start at t.

## Test plan
- N=15, in_data 1..15 streamed back-to-back, win_ready = 1 -> writes to addresses 0..14 in order. Windows (1,2,3)..(13,14,15) appear on consecutive cycles with win_idx 0..12. done pulses exactly once at start+31. busy falls the cycle after done.
- in_valid toggling 1,0,1,0 during LOAD -> rf_we follows in_valid, wr_cnt advances only on valid beats, and RUN begins only after the 15th accepted word.
- win_ready low for 3 cycles while win_idx=5 -> win_valid stays 1, win_idx stays 5, rf_re = 0 and ReadData is stable. On release, window 6 follows on the next cycle with no window lost or duplicated.
- start pulsed during LOAD and during RUN -> ignored, with counts and sequence identical to an undisturbed run. A start in the cycle done is high is also ignored, and the next start in IDLE restarts cleanly.
- rst asserted mid-RUN (win_idx=7) -> next cycle all outputs are at their reset values and the state is IDLE. A new start reloads and sweeps windows 0..12 fully.
- N=3 parameterisation, data 9,8,7 -> exactly one window (9,8,7) with win_idx 0, then done.
